ram_2p_host_arb: RTL and testbench

- Two-host round-robin arbiter that sits directly upstream of one port of the 32-bit dual-port RAM, e.g. when instruction and data hosts share port A.
- Accepts Ibex-style req/gnt/rvalid transactions from two hosts.
- Decodes the RAM address window and drives a single RAM port.
- Routes the fixed 1-cycle RAM response back to the owning host, and answers out-of-window accesses with an error response.

---
 rtl/ram_2p_host_arb.sv | 159 +++++++++++++++
 tb/tb_ram_2p_host_arb.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_2p_host_arb.sv
// Two-host round-robin arbiter in front of one 32-bit RAM port.
// Out-of-window accesses get an error response and are counted.
module ram_2p_host_arb #(
    parameter int unsigned Depth    = 128,
    parameter logic [31:0] BaseAddr = 32'h0010_0000
) (
    input  logic             clk_i,
    input  logic             rst_i,

    input  logic [1:0]       h_req_i,
    input  logic [1:0]       h_we_i,
    input  logic [1:0][3:0]  h_be_i,
    input  logic [1:0][31:0] h_addr_i,
    input  logic [1:0][31:0] h_wdata_i,
    output logic [1:0]       h_gnt_o,
    output logic [1:0]       h_rvalid_o,
    output logic [1:0][31:0] h_rdata_o,
    output logic [1:0]       h_err_o,

    output logic             dev_req_o,
    output logic             dev_we_o,
    output logic [3:0]       dev_be_o,
    output logic [31:0]      dev_addr_o,
    output logic [31:0]      dev_wdata_o,
    input  logic             dev_rvalid_i,
    input  logic [31:0]      dev_rdata_i,

    output logic [7:0]       err_cnt_o
);

    // 33-bit bounds so a window ending at the top of the address space cannot wrap.
    localparam logic [32:0] WinLo = {1'b0, BaseAddr};
    localparam logic [32:0] WinHi = WinLo + 33'(4 * Depth);

    logic        ptr_q, ptr_d;
    logic        resp_vld_q, resp_vld_d;
    logic        resp_host_q, resp_host_d;
    logic        resp_err_q, resp_err_d;
    logic        resp_we_q, resp_we_d;
    logic [7:0]  err_cnt_q, err_cnt_d;

    logic        gnt_vld;
    logic        gnt_idx;
    logic        sel_we;
    logic [3:0]  sel_be;
    logic [31:0] sel_addr;
    logic [31:0] sel_wdata;
    logic        in_win;

    // Arbitration; reset suppresses every grant.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = 1'b0;
        if (!rst_i) begin
            case (h_req_i)
                2'b01: begin
                    gnt_vld = 1'b1;
                    gnt_idx = 1'b0;
                end
                2'b10: begin
                    gnt_vld = 1'b1;
                    gnt_idx = 1'b1;
                end
                2'b11: begin
                    gnt_vld = 1'b1;
                    gnt_idx = ptr_q;
                end
                default: begin
                    gnt_vld = 1'b0;
                    gnt_idx = 1'b0;
                end
            endcase
        end
    end

    assign sel_we    = h_we_i[gnt_idx];
    assign sel_be    = h_be_i[gnt_idx];
    assign sel_addr  = h_addr_i[gnt_idx];
    assign sel_wdata = h_wdata_i[gnt_idx];

    assign in_win = ({1'b0, sel_addr} >= WinLo) && ({1'b0, sel_addr} < WinHi);

    always_comb begin
        h_gnt_o = 2'b00;
        if (gnt_vld) begin
            h_gnt_o[gnt_idx] = 1'b1;
        end
    end

    // Device port; data outputs stay quiet unless a grant is present.
    always_comb begin
        dev_req_o   = 1'b0;
        dev_we_o    = 1'b0;
        dev_be_o    = 4'b0000;
        dev_addr_o  = 32'h0;
        dev_wdata_o = 32'h0;
        if (gnt_vld) begin
            dev_req_o   = in_win;
            dev_we_o    = sel_we;
            dev_be_o    = sel_be;
            dev_addr_o  = sel_addr - BaseAddr;
            dev_wdata_o = sel_wdata;
        end
    end

    always_comb begin
        ptr_d       = ptr_q;
        resp_vld_d  = gnt_vld;
        resp_host_d = gnt_idx;
        resp_err_d  = gnt_vld && !in_win;
        resp_we_d   = gnt_vld && sel_we;
        err_cnt_d   = err_cnt_q;
        if (gnt_vld && (h_req_i == 2'b11)) begin
            ptr_d = ~gnt_idx;
        end
        if (gnt_vld && !in_win && (err_cnt_q != 8'hFF)) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr_q       <= 1'b0;
            resp_vld_q  <= 1'b0;
            resp_host_q <= 1'b0;
            resp_err_q  <= 1'b0;
            resp_we_q   <= 1'b0;
            err_cnt_q   <= 8'h00;
        end else begin
            ptr_q       <= ptr_d;
            resp_vld_q  <= resp_vld_d;
            resp_host_q <= resp_host_d;
            resp_err_q  <= resp_err_d;
            resp_we_q   <= resp_we_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    // A response still pending when reset arrives is dropped immediately.
    always_comb begin
        h_rvalid_o = 2'b00;
        h_err_o    = 2'b00;
        h_rdata_o  = '0;
        if (resp_vld_q && !rst_i) begin
            h_rvalid_o[resp_host_q] = 1'b1;
            h_err_o[resp_host_q]    = resp_err_q;
            if (!resp_err_q && !resp_we_q) begin
                h_rdata_o[resp_host_q] = dev_rdata_i;
            end
        end
    end

    assign err_cnt_o = err_cnt_q;

    // The RAM must answer exactly the in-window grants of the previous cycle.
    rvalid_track_a : assert property (@(posedge clk_i) disable iff (rst_i)
        dev_rvalid_i == (resp_vld_q && !resp_err_q));

endmodule

// File: tb/tb_ram_2p_host_arb.sv
// Directed bench for ram_2p_host_arb with a small behavioural RAM behind the device port.
module tb_ram_2p_host_arb;

    localparam int unsigned Depth = 128;
    localparam logic [31:0] Base  = 32'h0010_0000;
    localparam logic [31:0] ValA  = 32'h1111_2222;

    logic             clk_i = 1'b0;
    logic             rst_i;
    logic [1:0]       h_req_i;
    logic [1:0]       h_we_i;
    logic [1:0][3:0]  h_be_i;
    logic [1:0][31:0] h_addr_i;
    logic [1:0][31:0] h_wdata_i;
    logic [1:0]       h_gnt_o;
    logic [1:0]       h_rvalid_o;
    logic [1:0][31:0] h_rdata_o;
    logic [1:0]       h_err_o;
    logic             dev_req_o;
    logic             dev_we_o;
    logic [3:0]       dev_be_o;
    logic [31:0]      dev_addr_o;
    logic [31:0]      dev_wdata_o;
    logic             dev_rvalid_i = 1'b0;
    logic [31:0]      dev_rdata_i  = 32'h0;
    logic [7:0]       err_cnt_o;

    int checks   = 0;
    int failures = 0;

    logic [31:0] mem [Depth];

    ram_2p_host_arb #(.Depth(Depth), .BaseAddr(Base)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .h_req_i     (h_req_i),
        .h_we_i      (h_we_i),
        .h_be_i      (h_be_i),
        .h_addr_i    (h_addr_i),
        .h_wdata_i   (h_wdata_i),
        .h_gnt_o     (h_gnt_o),
        .h_rvalid_o  (h_rvalid_o),
        .h_rdata_o   (h_rdata_o),
        .h_err_o     (h_err_o),
        .dev_req_o   (dev_req_o),
        .dev_we_o    (dev_we_o),
        .dev_be_o    (dev_be_o),
        .dev_addr_o  (dev_addr_o),
        .dev_wdata_o (dev_wdata_o),
        .dev_rvalid_i(dev_rvalid_i),
        .dev_rdata_i (dev_rdata_i),
        .err_cnt_o   (err_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    // RAM model: 1-cycle response, byte-enabled writes, word 4 preloaded on reset.
    always @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < int'(Depth); i++) mem[i] <= 32'h0;
            mem[4]       <= 32'hDEAD_BEEF;
            dev_rvalid_i <= 1'b0;
            dev_rdata_i  <= 32'h0;
        end else begin
            dev_rvalid_i <= dev_req_o;
            if (dev_req_o) begin
                if (dev_we_o) begin
                    for (int b = 0; b < 4; b++) begin
                        if (dev_be_o[b]) mem[dev_addr_o[8:2]][8*b +: 8] <= dev_wdata_o[8*b +: 8];
                    end
                    dev_rdata_i <= 32'h0;
                end else begin
                    dev_rdata_i <= mem[dev_addr_o[8:2]];
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic set_host(input int h, input logic we, input logic [3:0] be,
                            input logic [31:0] addr, input logic [31:0] wdata);
        h_we_i[h]    = we;
        h_be_i[h]    = be;
        h_addr_i[h]  = addr;
        h_wdata_i[h] = wdata;
    endtask

    initial begin
        rst_i     = 1'b1;
        h_req_i   = 2'b00;
        h_we_i    = 2'b00;
        h_be_i    = '0;
        h_addr_i  = '0;
        h_wdata_i = '0;
        repeat (2) @(negedge clk_i);
        #1;
        check("rst_gnt", h_gnt_o, 2'b00);
        check("rst_rvalid", h_rvalid_o, 2'b00);
        check("rst_err", h_err_o, 2'b00);
        check("rst_rdata", h_rdata_o, 64'h0);
        check("rst_errcnt", err_cnt_o, 8'h00);
        check("rst_devreq", dev_req_o, 1'b0);

        // Single host0 read.
        @(negedge clk_i);
        rst_i = 1'b0;
        h_req_i = 2'b01;
        set_host(0, 1'b0, 4'hF, Base + 32'h10, 32'h0);
        #1;
        check("rd_gnt", h_gnt_o, 2'b01);
        check("rd_devreq", dev_req_o, 1'b1);
        check("rd_devaddr", dev_addr_o, 32'h10);
        @(negedge clk_i);
        h_req_i = 2'b00;
        #1;
        check("rd_rvalid", h_rvalid_o, 2'b01);
        check("rd_rdata0", h_rdata_o[0], 32'hDEAD_BEEF);
        check("rd_rdata1", h_rdata_o[1], 32'h0);
        check("rd_err", h_err_o, 2'b00);

        // Both hosts requesting: grants alternate 0,1,0,1.
        @(negedge clk_i);
        h_req_i = 2'b11;
        set_host(0, 1'b1, 4'hF, Base + 32'h20, ValA);
        set_host(1, 1'b0, 4'hF, Base + 32'h10, 32'h0);
        #1;
        check("rr0_gnt", h_gnt_o, 2'b01);
        check("rr0_devreq", dev_req_o, 1'b1);
        check("rr0_devwe", dev_we_o, 1'b1);
        check("rr0_wdata", dev_wdata_o, ValA);
        @(negedge clk_i);
        set_host(0, 1'b0, 4'hF, Base + 32'h20, 32'h0);
        #1;
        check("rr1_gnt", h_gnt_o, 2'b10);
        check("rr1_devreq", dev_req_o, 1'b1);
        check("rr1_rvalid", h_rvalid_o, 2'b01);
        check("rr1_rdata0", h_rdata_o[0], 32'h0);
        @(negedge clk_i);
        set_host(1, 1'b0, 4'hF, Base + 32'h20, 32'h0);
        #1;
        check("rr2_gnt", h_gnt_o, 2'b01);
        check("rr2_devreq", dev_req_o, 1'b1);
        check("rr2_rvalid", h_rvalid_o, 2'b10);
        check("rr2_rdata1", h_rdata_o[1], 32'hDEAD_BEEF);
        @(negedge clk_i);
        set_host(0, 1'b0, 4'hF, Base + 32'h10, 32'h0);
        #1;
        check("rr3_gnt", h_gnt_o, 2'b10);
        check("rr3_devreq", dev_req_o, 1'b1);
        check("rr3_rvalid", h_rvalid_o, 2'b01);
        check("rr3_rdata0", h_rdata_o[0], ValA);
        @(negedge clk_i);
        h_req_i = 2'b00;
        #1;
        check("rr4_rvalid", h_rvalid_o, 2'b10);
        check("rr4_rdata1", h_rdata_o[1], ValA);

        // Host1 write to the last word of the window.
        @(negedge clk_i);
        h_req_i = 2'b10;
        set_host(1, 1'b1, 4'b0011, Base + 32'(4 * Depth) - 32'd4, 32'hCAFE_F00D);
        #1;
        check("top_gnt", h_gnt_o, 2'b10);
        check("top_devreq", dev_req_o, 1'b1);
        check("top_devaddr", dev_addr_o, 32'(4 * Depth) - 32'd4);
        check("top_devbe", dev_be_o, 4'b0011);
        @(negedge clk_i);
        h_req_i = 2'b00;
        #1;
        check("top_rvalid", h_rvalid_o, 2'b10);
        check("top_rdata1", h_rdata_o[1], 32'h0);
        check("top_err", h_err_o, 2'b00);

        // Out-of-window: one past the end, then the top of the address space.
        @(negedge clk_i);
        h_req_i = 2'b01;
        set_host(0, 1'b0, 4'hF, Base + 32'(4 * Depth), 32'h0);
        #1;
        check("oow0_gnt", h_gnt_o, 2'b01);
        check("oow0_devreq", dev_req_o, 1'b0);
        @(negedge clk_i);
        set_host(0, 1'b0, 4'hF, 32'hFFFF_FFFC, 32'h0);
        #1;
        check("oow0_rvalid", h_rvalid_o, 2'b01);
        check("oow0_err", h_err_o, 2'b01);
        check("oow0_rdata", h_rdata_o[0], 32'h0);
        check("oow0_cnt", err_cnt_o, 8'd1);
        check("oow1_gnt", h_gnt_o, 2'b01);
        check("oow1_devreq", dev_req_o, 1'b0);
        @(negedge clk_i);
        h_req_i = 2'b00;
        #1;
        check("oow1_rvalid", h_rvalid_o, 2'b01);
        check("oow1_err", h_err_o, 2'b01);
        check("oow1_cnt", err_cnt_o, 8'd2);

        // 254 more out-of-window accesses: 256 in total saturates the counter.
        h_req_i = 2'b01;
        set_host(0, 1'b0, 4'hF, 32'h0, 32'h0);
        for (int i = 0; i < 254; i++) @(negedge clk_i);
        h_req_i = 2'b00;
        @(negedge clk_i);
        #1;
        check("sat_cnt", err_cnt_o, 8'hFF);

        // Reset mid-operation: pointer is at host1 and a response is pending.
        @(negedge clk_i);
        h_req_i = 2'b11;
        set_host(0, 1'b0, 4'hF, Base + 32'h10, 32'h0);
        set_host(1, 1'b0, 4'hF, Base + 32'h20, 32'h0);
        #1;
        check("pre_rst_gnt", h_gnt_o, 2'b01);
        @(negedge clk_i);
        rst_i = 1'b1;
        #1;
        check("midrst_rvalid", h_rvalid_o, 2'b00);
        check("midrst_gnt", h_gnt_o, 2'b00);
        check("midrst_devreq", dev_req_o, 1'b0);
        @(negedge clk_i);
        #1;
        check("postrst_rvalid", h_rvalid_o, 2'b00);
        check("postrst_cnt", err_cnt_o, 8'h00);
        rst_i = 1'b0;
        #1;
        check("postrst_gnt", h_gnt_o, 2'b01);
        @(negedge clk_i);
        h_req_i = 2'b00;
        #1;
        check("postrst_resp", h_rvalid_o, 2'b01);
        check("postrst_rdata", h_rdata_o[0], 32'hDEAD_BEEF);

        @(negedge clk_i);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
